// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: states, opcodes,
// datapath mux selects, ALU op and fault encodings, and opcode-to-format decode.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEM_RD,
    MEM_WR,
    EXEC_R,
    EXEC_I,
    WB_ALU,
    WB_MEM,
    BRANCH,
    JAL,
    FAULT
  } state_t;

  // RV32I major opcodes handled by this core subset
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  // Register-file writeback source select
  localparam logic [1:0] WB_SRC_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SRC_MDR    = 2'b01;
  localparam logic [1:0] WB_SRC_PC     = 2'b10;

  // ALU operation
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_LOAD,
    FMT_STORE,
    FMT_B,
    FMT_J,
    FMT_ILLEGAL
  } instr_format;

  // Classify a 32-bit instruction by its major opcode
  function automatic instr_format decode32_format(input logic [6:0] op);
    case (op)
      OP_R:      return FMT_R;
      OP_I:      return FMT_I;
      OP_LOAD:   return FMT_LOAD;
      OP_STORE:  return FMT_STORE;
      OP_BRANCH: return FMT_B;
      OP_JAL:    return FMT_J;
      default:   return FMT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified-memory request/ready handshake between the controller and memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts stalled memory cycles and flags the cycle on which the wait limit
// is reached without a ready response.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  input  logic clr,
  output logic expired
);

  localparam int unsigned W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] wait_cnt;

  // Count stalled request cycles; cleared on completion or state change
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n || clr || (req && ready)) begin
      wait_cnt <= '0;
    end else if (req) begin
      wait_cnt <= wait_cnt + ONE;
    end
  end

  // A ready on the limit cycle wins over the timeout
  assign expired = req && !ready && (wait_cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I subset (R-type, lw, addi, sw, beq,
// jal) driving a shared-memory single-ALU datapath.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  multicycle_ctrl_if.master    mem,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic [1:0]           mem_to_reg,
  output logic                 retire,
  output logic [CNT_W-1:0]     instret,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       code_d;
  logic             mem_req_c, mem_we_c, iord_c;
  logic             timeout;
  logic [CNT_W-1:0] instret_q;
  logic             fault_q;
  logic [1:0]       fault_code_q;

  // Memory request: FETCH only while run is high, plus the data-access states
  assign mem_req_c = rst_n && (((state_q == FETCH) && run) ||
                               (state_q == MEM_RD) || (state_q == MEM_WR));

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (mem_req_c),
    .ready   (mem.mem_ready),
    .clr     (state_d != state_q),
    .expired (timeout)
  );

  // Next-state and datapath control decode
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    code_d     = FAULT_NONE;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = WB_SRC_ALUOUT;
    retire     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          if (run) begin
            alu_src_b = SRC_B_FOUR;
            if (mem.mem_ready) begin
              ir_write = 1'b1;
              pc_en    = 1'b1;
              state_d  = DECODE;
            end else if (timeout) begin
              state_d = FAULT;
              code_d  = FAULT_TIMEOUT;
            end
          end
        end
        DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          unique case (decode32_format(opcode))
            FMT_R:             state_d = EXEC_R;
            FMT_I:             state_d = EXEC_I;
            FMT_LOAD, FMT_STORE: state_d = MEMADR;
            FMT_B:             state_d = BRANCH;
            FMT_J:             state_d = JAL;
            default: begin
              state_d = FAULT;
              code_d  = FAULT_ILLEGAL;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          state_d   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          iord_c = 1'b1;
          if (mem.mem_ready) begin
            state_d = WB_MEM;
          end else if (timeout) begin
            state_d = FAULT;
            code_d  = FAULT_TIMEOUT;
          end
        end
        MEM_WR: begin
          iord_c   = 1'b1;
          mem_we_c = 1'b1;
          if (mem.mem_ready) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else if (timeout) begin
            state_d = FAULT;
            code_d  = FAULT_TIMEOUT;
          end
        end
        EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_FUNCT;
          state_d   = WB_ALU;
        end
        EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          state_d   = WB_ALU;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_SRC_MDR;
          retire     = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_SUB;
          pc_src    = PC_SRC_ALUOUT;
          pc_en     = zero;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        JAL: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_SRC_PC;
          pc_en      = 1'b1;
          pc_src     = PC_SRC_ALUOUT;
          retire     = 1'b1;
          state_d    = FETCH;
        end
        FAULT:   state_d = FAULT;
        default: state_d = FETCH;
      endcase
    end
  end

  // State, retired-instruction count and sticky fault registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      instret_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + CNT_ONE;
      end
      if ((state_d == FAULT) && (state_q != FAULT)) begin
        fault_q      <= 1'b1;
        fault_code_q <= code_d;
      end
    end
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign mem.iord    = iord_c;
  assign instret     = instret_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected
// retire/fault event per instruction; a monitor pops and compares on each
// retire pulse or fault assertion.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int K_RETIRE = 0;
  localparam int K_FAULT  = 1;
  localparam int K_NONE   = 2;
  localparam int NEVER    = 100;

  typedef struct {
    int         kind;
    int         lat;
    logic [1:0] code;
    logic [2:0] instret;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [6:0] opcode;
  logic       zero;
  logic       ir_write, pc_en, reg_write, retire, fault;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, fault_code;
  logic [2:0] instret;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mif.master),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .retire     (retire),
    .instret    (instret),
    .fault      (fault),
    .fault_code (fault_code)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pending = 0;
  exp_t exp_q[$];
  logic [2:0] exp_instret = 3'd0;

  // Memory model: ready after a configured number of stalled cycles
  int fetch_wait = 0;
  int data_wait  = 0;
  int wcnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb mif.mem_ready = mif.mem_req && (wcnt == (mif.iord ? data_wait : fetch_wait));

  always @(posedge clk) begin
    if (!mif.mem_req || mif.mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each retire or fault event
  initial begin : monitor
    bit   in_flight = 0;
    bit   fault_seen = 0;
    bit   instret_due = 0;
    int   start_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_flight   = 0;
        fault_seen  = 0;
        instret_due = 0;
      end else begin
        if (instret_due) begin
          check("instret", 32'(instret), 32'(e.instret));
          instret_due = 0;
          pending--;
        end
        if (!in_flight && mif.mem_req && !mif.iord) begin
          in_flight = 1;
          start_cyc = cyc;
        end
        if (retire || (fault && !fault_seen)) begin
          if (fault) fault_seen = 1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: retire=%0b fault=%0b with empty scoreboard, required none", retire, fault);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(fault ? K_FAULT : K_RETIRE), 32'(e.kind));
            check("latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
            check("event_fault_code", 32'(fault_code), 32'(e.code));
            instret_due = 1;
          end
          in_flight = 0;
        end
      end
    end
  end

  // Issue one instruction: set inputs, push the expectation, fetch it, drop run
  task automatic issue(input logic [6:0] op, input logic z, input int fw, input int dw,
                       input int kind, input int lat, input logic [1:0] code, input int hold);
    exp_t e;
    bit   got = 0;
    opcode = op;
    zero = z;
    fetch_wait = fw;
    data_wait = dw;
    if (kind == K_RETIRE) exp_instret = exp_instret + 3'd1;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.lat = lat;
      e.code = (kind == K_FAULT) ? code : 2'b00;
      e.instret = exp_instret;
      exp_q.push_back(e);
      pending++;
    end
    @(posedge clk);
    #1 run = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ir_write) got = 1;
    end
    check("fetch_ctrl", 32'({mif.mem_req, mif.iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op}),
          32'(12'b1_0_1_1_00_00_01_00));
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1 run = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (pending != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (pending != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: %0d events outstanding after %0d cycles, required 0", pending, n);
      exp_q.delete();
      pending = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    run = 1'b0;
    exp_q.delete();
    pending = 0;
    exp_instret = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({mif.mem_req, mif.mem_we, mif.iord, ir_write, pc_en, pc_src, alu_src_a,
                                alu_src_b, alu_op, reg_write, mem_to_reg, retire, fault, fault_code}), 32'h0);
    check("reset_instret", 32'(instret), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic count_req(input int n, input bit data, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mif.mem_req && (mif.iord == data)) cnt++;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    rst_n = 1'b0;
    run = 1'b0;
    opcode = 7'd0;
    zero = 1'b0;
    do_reset();

    // R-type, zero-wait memory: FETCH, DECODE, EXEC_R, WB_ALU
    issue(OP_R, 1'b0, 0, 0, K_RETIRE, 4, 2'b00, 0);
    @(negedge clk);
    check("decode_ctrl", 32'({alu_src_a, alu_src_b, alu_op, mif.mem_req}), 32'(7'b10_10_00_0));
    @(negedge clk);
    check("exec_r_ctrl", 32'({alu_src_a, alu_src_b, alu_op}), 32'(6'b01_00_10));
    @(negedge clk);
    check("wb_alu_ctrl", 32'({reg_write, mem_to_reg, retire}), 32'(4'b1_00_1));
    wait_done();
    count_req(3, 1'b0, n);
    check("idle_fetch_no_req", 32'(n), 32'd0);

    // lw with three data wait cycles (ready on the limit cycle)
    issue(OP_LOAD, 1'b0, 0, 3, K_RETIRE, 8, 2'b00, 0);
    @(negedge clk);
    @(negedge clk);
    check("memadr_ctrl", 32'({alu_src_a, alu_src_b, alu_op}), 32'(6'b01_10_00));
    count_req(4, 1'b1, n);
    check("lw_req_cycles", 32'(n), 32'd4);
    @(negedge clk);
    check("wb_mem_ctrl", 32'({reg_write, mem_to_reg, retire}), 32'(4'b1_01_1));
    wait_done();

    // beq taken and not taken
    issue(OP_BRANCH, 1'b1, 0, 0, K_RETIRE, 3, 2'b00, 0);
    @(negedge clk);
    @(negedge clk);
    check("beq_taken_ctrl", 32'({pc_en, pc_src, alu_src_a, alu_src_b, alu_op, retire}), 32'(10'b1_01_01_00_01_1));
    wait_done();
    issue(OP_BRANCH, 1'b0, 0, 0, K_RETIRE, 3, 2'b00, 0);
    @(negedge clk);
    @(negedge clk);
    check("beq_not_taken_ctrl", 32'({pc_en, pc_src, alu_src_a, alu_src_b, alu_op, retire}), 32'(10'b0_01_01_00_01_1));
    wait_done();

    // addi and jal
    issue(OP_I, 1'b0, 0, 0, K_RETIRE, 4, 2'b00, 0);
    @(negedge clk);
    @(negedge clk);
    check("exec_i_ctrl", 32'({alu_src_a, alu_src_b, alu_op}), 32'(6'b01_10_00));
    wait_done();
    issue(OP_JAL, 1'b0, 0, 0, K_RETIRE, 3, 2'b00, 0);
    @(negedge clk);
    @(negedge clk);
    check("jal_ctrl", 32'({reg_write, mem_to_reg, pc_en, pc_src, retire}), 32'(7'b1_10_1_01_1));
    wait_done();

    // sw with ready on the timeout limit cycle: completes, no fault
    issue(OP_STORE, 1'b0, 0, 3, K_RETIRE, 7, 2'b00, 0);
    wait_done();
    check("sw_limit_no_fault", 32'(fault), 32'd0);

    // R-type with run dropped during EXEC_R; instret wraps 7 -> 0
    issue(OP_R, 1'b0, 0, 0, K_RETIRE, 4, 2'b00, 1);
    wait_done();
    count_req(4, 1'b0, n);
    check("halt_after_run_drop", 32'(n), 32'd0);

    // jal with two fetch wait cycles
    issue(OP_JAL, 1'b0, 2, 0, K_RETIRE, 5, 2'b00, 0);
    wait_done();

    // Reset during a MEM_WR wait
    issue(OP_STORE, 1'b0, 0, NEVER, K_NONE, 0, 2'b00, 0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    pending = 0;
    exp_instret = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_mid_wr_outputs", 32'({mif.mem_req, mif.mem_we, mif.iord, reg_write, retire, pc_en}), 32'h0);
    check("reset_mid_wr_instret", 32'(instret), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Illegal opcode: fault code 01, no further requests, instret frozen
    issue(7'b1111111, 1'b0, 0, 0, K_FAULT, 3, 2'b01, 0);
    wait_done();
    run = 1'b1;
    count_req(6, 1'b0, n);
    check("fault_no_req", 32'(n), 32'd0);
    check("fault_code_hold", 32'({fault, fault_code}), 32'(3'b1_01));
    check("fault_instret_frozen", 32'(instret), 32'd0);
    run = 1'b0;

    // sw with memory never ready: four request cycles, then timeout fault
    do_reset();
    issue(OP_STORE, 1'b0, 0, NEVER, K_FAULT, 8, 2'b10, 0);
    @(negedge clk);
    @(negedge clk);
    count_req(8, 1'b1, n);
    check("sw_timeout_req_cycles", 32'(n), 32'd4);
    wait_done();
    check("timeout_fault", 32'({fault, fault_code}), 32'(3'b1_10));

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core subset: R-type, lw, addi, sw, beq and jal. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps, one step per state. It drives a req/ready handshake to unified memory and counts retired instructions. It faults on illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before fault (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
run  in  1  permit new instruction fetch
opcode  in  7  IR[6:0], valid from DECODE onward
zero  in  1  ALU zero flag (beq compare)
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write request (valid with mem_req)
iord  out  1  address mux: 0=PC, 1=ALUOut
ir_write  out  1  load IR and old_pc
pc_en  out  1  PC load enable
pc_src  out  2  00=ALU result, 01=ALUOut
alu_src_a  out  2  00=PC, 01=rs1, 10=old_pc
alu_src_b  out  2  00=rs2, 01=const 4, 10=imm
alu_op  out  2  00=add, 01=sub/compare, 10=funct-decoded
reg_write  out  1  register file write
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC (link)
retire  out  1  one-cycle pulse per completed instruction
instret  out  CNT_W  retired-instruction count
fault  out  1  sticky error
fault_code  out  2  00=none, 01=illegal opcode, 10=memory timeout

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low. While rst_n=0, state<=FETCH, wait_cnt<=0, instret<=0, fault<=0, fault_code<=00. All outputs are 0 during reset.
- Outputs are Moore, decoded from state, except three terms. pc_en in FETCH is qualified by mem_ready. ir_write is qualified by mem_ready. In BRANCH, pc_en=zero. Unlisted outputs are 0.
- FETCH:
  - run=0: no request is issued, wait_cnt holds, state holds.
  - run=1: mem_req=1, iord=0, a=00, b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_en=1, pc_src=00, then go to DECODE.
- DECODE: a=10, b=10, alu_op=00, so ALUOut=branch/jump target. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other -> FAULT with code 01
- MEMADR: a=01, b=10, alu_op=00. Next is MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, iord=1. On mem_ready go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready go to FETCH and retire.
- EXEC_R: a=01, b=00, alu_op=10, then WB_ALU.
- EXEC_I: a=01, b=10, alu_op=00, then WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=00, then FETCH and retire.
- WB_MEM: reg_write=1, mem_to_reg=01, then FETCH and retire.
- BRANCH: a=01, b=00, alu_op=01, pc_src=01, pc_en=zero, then FETCH and retire.
- JAL: reg_write=1, mem_to_reg=10, pc_en=1, pc_src=01, then FETCH and retire.
- Latency with zero-wait memory (mem_ready same cycle as mem_req):
  - beq, jal: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
  - Each memory wait cycle adds 1.
- Timeout:
  - wait_cnt increments each cycle a memory state (FETCH with run=1, MEM_RD, MEM_WR) sees mem_req=1 and mem_ready=0.
  - If wait_cnt=MEM_TIMEOUT-1 and mem_ready=0, go to FAULT with code 10.
  - wait_cnt clears on mem_ready and on leaving the state.
  - If mem_ready arrives on the limit cycle, it wins.
- mem_ready is ignored outside memory states.
- run is sampled only in FETCH. Deasserting run mid-instruction lets that instruction complete; the block halts at the next FETCH.
- retire is asserted on the final-state cycle, and instret increments in the same cycle. instret wraps modulo 2^CNT_W with no flag.
- FAULT: all datapath outputs are 0, fault=1, fault_code holds. Only reset exits this state. instret is frozen; the faulting instruction does not retire.
- Reset asserted mid-instruction (e.g. during MEM_WR wait) drops mem_req the next cycle. No partial writeback follows.

Decomposition:
- Shared core package holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - mux-select localparams for alu_src_a/b, pc_src, mem_to_reg
  - alu_op encodings
  - fault_code values
- Reuse the package's existing instr_format / decode32_format for the DECODE dispatch.
- One natural sub-module, mem_wait_timer: wait_cnt plus the timeout compare, parameterised by MEM_TIMEOUT.
- Next-state logic and output decode stay in the top.

Test Plan:
- Reset then run=1, zero-wait memory, opcode=0110011: states FETCH, DECODE, EXEC_R, WB_ALU. retire on cycle 4, instret=1. alu_op=10 in EXEC_R.
- lw (0000011) with mem_ready delayed 3 cycles in MEM_RD: mem_req stays high 4 cycles at iord=1. WB_MEM has mem_to_reg=01. Total 8 cycles.
- beq with zero=1, then beq with zero=0: pc_en=1 then pc_en=0 in BRANCH. Both retire; instret=2.
- opcode=1111111 in DECODE: fault=1 and fault_code=01 the next cycle. mem_req stays 0 forever. instret unchanged.
- MEM_TIMEOUT=4, sw with mem_ready never asserted: mem_req high 4 cycles, then FAULT with code 10. Repeat with mem_ready on the 4th cycle: retire occurs and no fault.
- run dropped during EXEC_R: instruction retires, FETCH holds with mem_req=0. Separately, rst_n=0 during an MEM_WR wait: next cycle state=FETCH, all outputs 0, instret=0.
